// File: rtl/aes_pkg.sv
// Shared AES types and constants.
// Used by the key schedule and the cipher datapath.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam int unsigned NR = 10;
    localparam int unsigned NK = 4;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // {a,b,c,d} -> {b,c,d,a}
    function automatic aes_word_t rot_word(input aes_word_t x);
        return {x[23:0], x[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a flat lookup table.
// Shared by the key schedule and the cipher rounds.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Table lookup; every input byte has an entry.
    always_comb begin
        y = 8'h00;
        case (a)
            8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b;
            8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
            8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b;
            8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
            8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d;
            8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
            8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf;
            8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
            8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26;
            8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
            8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1;
            8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
            8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3;
            8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
            8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2;
            8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
            8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a;
            8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
            8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3;
            8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
            8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed;
            8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
            8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39;
            8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
            8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb;
            8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
            8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f;
            8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
            8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f;
            8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
            8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21;
            8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
            8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec;
            8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
            8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d;
            8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
            8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc;
            8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
            8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14;
            8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
            8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a;
            8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
            8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62;
            8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
            8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d;
            8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
            8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea;
            8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
            8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e;
            8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
            8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f;
            8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
            8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66;
            8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
            8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9;
            8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
            8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11;
            8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
            8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9;
            8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
            8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d;
            8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
            8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f;
            8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule: all ten round keys, expanded combinationally
// from the cipher key and presented together one clock later.
module key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] aes_key,
    output logic [127:0] key1,
    output logic [127:0] key2,
    output logic [127:0] key3,
    output logic [127:0] key4,
    output logic [127:0] key5,
    output logic [127:0] key6,
    output logic [127:0] key7,
    output logic [127:0] key8,
    output logic [127:0] key9,
    output logic [127:0] key10
);

    localparam int NW = NK * (NR + 1);

    aes_word_t  w    [0:NW-1];
    aes_block_t rk_d [1:NR];
    aes_block_t rk_q [1:NR];

    assign w[0] = aes_key[127:96];
    assign w[1] = aes_key[95:64];
    assign w[2] = aes_key[63:32];
    assign w[3] = aes_key[31:0];

    for (genvar r = 1; r <= NR; r++) begin : g_round
        aes_word_t rot;
        aes_word_t sub;

        assign rot = rot_word(w[NK*r-1]);

        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .a (rot[8*b +: 8]),
                .y (sub[8*b +: 8])
            );
        end

        assign w[NK*r]   = w[NK*r-4] ^ sub ^ {RCON[r], 24'h0};
        assign w[NK*r+1] = w[NK*r-3] ^ w[NK*r];
        assign w[NK*r+2] = w[NK*r-2] ^ w[NK*r+1];
        assign w[NK*r+3] = w[NK*r-1] ^ w[NK*r+2];

        assign rk_d[r] = {w[NK*r], w[NK*r+1], w[NK*r+2], w[NK*r+3]};
    end

    // Capture every round key on the same edge so no mix of keys is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            for (int i = 1; i <= NR; i++) rk_q[i] <= rk_d[i];
        end
    end

    assign key1  = rk_q[1];
    assign key2  = rk_q[2];
    assign key3  = rk_q[3];
    assign key4  = rk_q[4];
    assign key5  = rk_q[5];
    assign key6  = rk_q[6];
    assign key7  = rk_q[7];
    assign key8  = rk_q[8];
    assign key9  = rk_q[9];
    assign key10 = rk_q[10];

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: known FIPS-197 vectors plus a
// scoreboard of model-predicted key sets over random keys.
module tb_key_expand;

    typedef logic [1:10][127:0] set_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] aes_key;
    logic [127:0] key1, key2, key3, key4, key5;
    logic [127:0] key6, key7, key8, key9, key10;

    set_t got;
    set_t cur;
    set_t exp_q [$];
    logic [7:0] sb_m [0:255];

    int n_pass  = 0;
    int n_total = 0;

    key_expand dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .aes_key (aes_key),
        .key1    (key1),
        .key2    (key2),
        .key3    (key3),
        .key4    (key4),
        .key5    (key5),
        .key6    (key6),
        .key7    (key7),
        .key8    (key8),
        .key9    (key9),
        .key10   (key10)
    );

    assign got = {key1, key2, key3, key4, key5,
                  key6, key7, key8, key9, key10};

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb_m[a] = s;
        end
    endtask

    function automatic set_t model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        set_t        o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int j = 4; j < 44; j++) begin
            t = w[j-1];
            if (j % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[j] = w[j-4] ^ t;
        end
        for (int r = 1; r <= 10; r++)
            o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        aes_key = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        #2;
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== 128'h0)
                $display("FAIL reset_async key%0d got %h exp 0", r, got[r]);
            else n_pass++;
        end
        @(negedge clk);
        aes_key = 128'h0;
        rst_n   = 1'b1;
        exp_q.push_back(model(aes_key));
        @(posedge clk); #1;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL reset_sb queue empty");
        end else begin
            n_pass++;
            cur = exp_q.pop_front();
        end
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== cur[r])
                $display("FAIL zero_sb key%0d got %h exp %h", r, got[r], cur[r]);
            else n_pass++;
        end
        n_total++;
        if (key1 !== 128'h62636363_62636363_62636363_62636363)
            $display("FAIL zero_key1 got %h", key1);
        else n_pass++;
        n_total++;
        if (key10 !== 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e)
            $display("FAIL zero_key10 got %h", key10);
        else n_pass++;
    endtask

    task automatic test_zero_round2();
        n_total++;
        if (key2 !== 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa)
            $display("FAIL zero_key2 got %h", key2);
        else n_pass++;
        @(posedge clk); #1;
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== cur[r])
                $display("FAIL hold key%0d got %h exp %h", r, got[r], cur[r]);
            else n_pass++;
        end
    endtask

    task automatic test_fips();
        @(negedge clk);
        aes_key = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        exp_q.push_back(model(aes_key));
        @(posedge clk); #1;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL fips_sb queue empty");
        end else begin
            n_pass++;
            cur = exp_q.pop_front();
        end
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== cur[r])
                $display("FAIL fips_sb key%0d got %h exp %h", r, got[r], cur[r]);
            else n_pass++;
        end
        n_total++;
        if (key1 !== 128'ha0fafe17_88542cb1_23a33939_2a6c7605)
            $display("FAIL fips_key1 got %h", key1);
        else n_pass++;
        n_total++;
        if (key10 !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6)
            $display("FAIL fips_key10 got %h", key10);
        else n_pass++;
    endtask

    task automatic test_latency();
        @(negedge clk);
        aes_key = 128'h00112233_44556677_8899aabb_ccddeeff;
        exp_q.push_back(model(aes_key));
        #3;
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== cur[r])
                $display("FAIL latency_old key%0d got %h exp %h", r, got[r], cur[r]);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL latency_sb queue empty");
        end else begin
            n_pass++;
            cur = exp_q.pop_front();
        end
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== cur[r])
                $display("FAIL latency_new key%0d got %h exp %h", r, got[r], cur[r]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        aes_key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        #1;
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== 128'h0)
                $display("FAIL midrst_async key%0d got %h exp 0", r, got[r]);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_total++;
        if (key5 !== 128'h0)
            $display("FAIL midrst_held key5 got %h exp 0", key5);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(aes_key));
        @(posedge clk); #1;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL midrst_sb queue empty");
        end else begin
            n_pass++;
            cur = exp_q.pop_front();
        end
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== cur[r])
                $display("FAIL midrst_reload key%0d got %h exp %h", r, got[r], cur[r]);
            else n_pass++;
        end
    endtask

    task automatic test_ones();
        @(negedge clk);
        aes_key = {128{1'b1}};
        exp_q.push_back(model(aes_key));
        @(posedge clk); #1;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL ones_sb queue empty");
        end else begin
            n_pass++;
            cur = exp_q.pop_front();
        end
        for (int r = 1; r <= 10; r++) begin
            n_total++;
            if (got[r] !== cur[r])
                $display("FAIL ones_sb key%0d got %h exp %h", r, got[r], cur[r]);
            else n_pass++;
        end
        n_total++;
        if (key1 !== 128'he8e9e9e9_17161616_e8e9e9e9_17161616)
            $display("FAIL ones_key1 got %h", key1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nbad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            aes_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp_q.push_back(model(aes_key));
            @(posedge clk); #1;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rand_sb queue empty");
            end else begin
                n_pass++;
                cur = exp_q.pop_front();
            end
            for (int r = 1; r <= 10; r++) begin
                n_total++;
                if (got[r] !== cur[r]) begin
                    if (nbad < 10)
                        $display("FAIL rand%0d key%0d got %h exp %h",
                                 i, r, got[r], cur[r]);
                    nbad++;
                end else n_pass++;
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        aes_key = '0;
        build_sbox();
        test_reset();
        test_zero_round2();
        test_fips();
        test_latency();
        test_reset_midstream();
        test_ones();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
